// File: rtl/pbvi_converge_if.sv
// Launch/result link between pbvi_converge (master) and the step123 backup stage (slave).
interface pbvi_converge_if #(
  parameter int NPT = 16,
  parameter int NS  = 2
);
  logic                         en_step;
  logic [0:NPT-1][0:NS-1][15:0] alpha_fb;
  logic                         en_loop;
  logic [0:NPT-1][0:NS-1][15:0] alpha_out;
  logic [0:NPT-1][1:0]          point_action;

  modport master (
    output en_step,
    output alpha_fb,
    input  en_loop,
    input  alpha_out,
    input  point_action
  );

  modport slave (
    input  en_step,
    input  alpha_fb,
    output en_loop,
    output alpha_out,
    output point_action
  );
endinterface

// File: rtl/pbvi_converge.sv
// PBVI convergence controller: launches step123, compares each returned alpha set point by point, relaunches or stops.
// start->en_step 1 cycle, en_loop->relaunch/done 18 cycles; no backpressure, step123 is never relaunched before DECIDE ends.
module pbvi_converge #(
  parameter int NPT = 16,
  parameter int NS  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [0:NPT-1][0:NS-1][15:0] alpha_init,
  input  logic [15:0]                  epsilon,
  input  logic [7:0]                   max_iter,
  pbvi_converge_if.master              step,
  output logic [0:NPT-1][1:0]          policy,
  output logic [15:0]                  max_delta,
  output logic [7:0]                   iter_count,
  output logic                         busy,
  output logic                         done,
  output logic                         converged
);

  localparam int KW = $clog2(NPT);

  typedef logic [0:NPT-1][0:NS-1][15:0] aset_t;
  typedef logic [0:NPT-1][1:0]          aact_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_COMPARE,
    S_DECIDE,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  aset_t         alpha_fb_q, alpha_fb_d;
  aset_t         cap_q, cap_d;
  aact_t         cap_act_q, cap_act_d;
  aact_t         policy_q, policy_d;
  logic [15:0]   max_delta_q, max_delta_d;
  logic [7:0]    iter_q, iter_d;
  logic          conv_q, conv_d;
  logic [15:0]   eps_q, eps_d;
  logic [7:0]    max_iter_q, max_iter_d;
  logic [15:0]   run_max_q, run_max_d;
  logic [KW-1:0] k_q, k_d;
  logic          en_step_q;

  logic [15:0]   cmp_max;
  logic [7:0]    iter_inc;

  function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign iter_inc = iter_q + 8'd1;

  // Running maximum including both states of the point selected by k.
  always_comb begin
    cmp_max = run_max_q;
    for (int s = 0; s < NS; s++) begin
      if (abs_diff(cap_q[k_q][s], alpha_fb_q[k_q][s]) > cmp_max) begin
        cmp_max = abs_diff(cap_q[k_q][s], alpha_fb_q[k_q][s]);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    alpha_fb_d  = alpha_fb_q;
    cap_d       = cap_q;
    cap_act_d   = cap_act_q;
    policy_d    = policy_q;
    max_delta_d = max_delta_q;
    iter_d      = iter_q;
    conv_d      = conv_q;
    eps_d       = eps_q;
    max_iter_d  = max_iter_q;
    run_max_d   = run_max_q;
    k_d         = k_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          alpha_fb_d  = alpha_init;
          eps_d       = epsilon;
          max_iter_d  = max_iter;
          iter_d      = '0;
          max_delta_d = '0;
          conv_d      = 1'b0;
          policy_d    = '0;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        run_max_d = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (step.en_loop) begin
          cap_d     = step.alpha_out;
          cap_act_d = step.point_action;
          k_d       = '0;
          state_d   = S_COMPARE;
        end
      end
      S_COMPARE: begin
        run_max_d        = cmp_max;
        alpha_fb_d[k_q]  = cap_q[k_q];
        policy_d[k_q]    = cap_act_q[k_q];
        k_d              = k_q + KW'(1);
        if (k_q == KW'(NPT - 1)) begin
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        max_delta_d = run_max_q;
        iter_d      = iter_inc;
        // max_iter of 0 matches only after the 8-bit counter wraps, i.e. 256 iterations.
        if (run_max_q <= eps_q) begin
          conv_d  = 1'b1;
          state_d = S_DONE;
        end else if (iter_inc == max_iter_q) begin
          conv_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_LAUNCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      alpha_fb_q  <= '0;
      cap_q       <= '0;
      cap_act_q   <= '0;
      policy_q    <= '0;
      max_delta_q <= '0;
      iter_q      <= '0;
      conv_q      <= 1'b0;
      eps_q       <= '0;
      max_iter_q  <= '0;
      run_max_q   <= '0;
      k_q         <= '0;
      en_step_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alpha_fb_q  <= alpha_fb_d;
      cap_q       <= cap_d;
      cap_act_q   <= cap_act_d;
      policy_q    <= policy_d;
      max_delta_q <= max_delta_d;
      iter_q      <= iter_d;
      conv_q      <= conv_d;
      eps_q       <= eps_d;
      max_iter_q  <= max_iter_d;
      run_max_q   <= run_max_d;
      k_q         <= k_d;
      en_step_q   <= (state_d == S_LAUNCH);
    end
  end

  assign step.en_step  = en_step_q;
  assign step.alpha_fb = alpha_fb_q;
  assign policy        = policy_q;
  assign max_delta     = max_delta_q;
  assign iter_count    = iter_q;
  assign converged     = conv_q;
  assign done          = (state_q == S_DONE);
  assign busy          = (state_q == S_LAUNCH) || (state_q == S_WAIT) ||
                         (state_q == S_COMPARE) || (state_q == S_DECIDE);

endmodule

// File: tb/tb_pbvi_converge.sv
// Bench for pbvi_converge: behavioural step123 responder, vector table of solves, scoreboard of final status.
module tb_pbvi_converge;

  typedef logic [0:15][0:1][15:0] aset_t;
  typedef logic [0:15][1:0]       act_t;
  typedef enum int {M_IDENT, M_SINGLE, M_ALT, M_EXT_HI, M_EXT_MID} mode_e;

  typedef struct {
    mode_e       mode;
    logic [15:0] eps;
    logic [7:0]  mi;
    act_t        act;
    logic        exp_conv;
    logic [7:0]  exp_iter;
    logic [15:0] exp_delta;
    int          exp_steps;
    logic [15:0] exp_d1;
  } vec_t;

  typedef struct {
    logic        conv;
    logic [7:0]  iter;
    logic [15:0] delta;
    act_t        pol;
    int          steps;
    logic [15:0] d1;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  aset_t       alpha_init;
  logic [15:0] epsilon;
  logic [7:0]  max_iter;
  act_t        policy;
  logic [15:0] max_delta;
  logic [7:0]  iter_count;
  logic        busy;
  logic        done;
  logic        converged;

  pbvi_converge_if #(.NPT(16), .NS(2)) step ();

  pbvi_converge #(.NPT(16), .NS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .alpha_init(alpha_init),
    .epsilon   (epsilon),
    .max_iter  (max_iter),
    .step      (step),
    .policy    (policy),
    .max_delta (max_delta),
    .iter_count(iter_count),
    .busy      (busy),
    .done      (done),
    .converged (converged)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          step_total = 0;
  int          last_loop_cyc = -100;
  logic [15:0] delta_log [0:2047];

  mode_e cur_mode;
  act_t  cur_act;
  bit    spur_loop;
  int    inj_req;
  int    inj_ack;
  int    model_idx;
  aset_t last_resp;
  exp_t  sb[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (step.en_step) begin
      if (step_total < 2048) delta_log[step_total] <= max_delta;
      step_total <= step_total + 1;
    end
    if (step.en_loop) last_loop_cyc <= cyc;
  end

  function automatic aset_t init_set(input mode_e m);
    aset_t a;
    a = '0;
    for (int k = 0; k < 16; k++) begin
      for (int s = 0; s < 2; s++) begin
        case (m)
          M_IDENT, M_SINGLE: a[k][s] = (s == 0) ? 16'(13464 + k * 7209 / 15) : 16'(20673 - k * 7209 / 15);
          M_ALT:             a[k][s] = 16'h1000;
          default:           a[k][s] = 16'h0000;
        endcase
      end
    end
    if (m == M_EXT_HI) a[0][0] = 16'hFFFF;
    return a;
  endfunction

  function automatic aset_t make_resp(input mode_e m, input int idx, input aset_t fb);
    aset_t r;
    r = fb;
    case (m)
      M_SINGLE:  if (idx == 0) r[7][1] = fb[7][1] + 16'd300;
      M_ALT: begin
        for (int k = 0; k < 16; k++)
          for (int s = 0; s < 2; s++)
            r[k][s] = (idx % 2 == 0) ? 16'h1400 : 16'h1000;
      end
      M_EXT_HI:  r = '0;
      M_EXT_MID: if (idx == 0) r[5][1] = 16'h8000;
      default: ;
    endcase
    return r;
  endfunction

  // step123 stand-in: answers each en_step 5 cycles later, optionally followed by a stray en_loop.
  initial begin
    aset_t resp;
    step.en_loop      = 1'b0;
    step.alpha_out    = '0;
    step.point_action = '0;
    model_idx = 0;
    inj_ack   = 0;
    last_resp = '0;
    forever begin
      @(negedge clk);
      if (rst || (start && !busy)) model_idx = 0;
      if (step.en_step) begin
        resp = make_resp(cur_mode, model_idx, step.alpha_fb);
        model_idx++;
        repeat (5) @(posedge clk);
        #1;
        step.en_loop      = 1'b1;
        step.alpha_out    = resp;
        step.point_action = cur_act;
        last_resp         = resp;
        @(posedge clk);
        #1 step.en_loop = 1'b0;
        if (spur_loop) begin
          repeat (2) @(posedge clk);
          #1;
          step.en_loop      = 1'b1;
          step.alpha_out    = ~resp;
          step.point_action = ~cur_act;
          @(posedge clk);
          #1 step.en_loop = 1'b0;
        end
      end else if (inj_req != inj_ack) begin
        @(posedge clk);
        #1;
        step.en_loop   = 1'b1;
        step.alpha_out = {16{32'h5A5AA5A5}};
        @(posedge clk);
        #1 step.en_loop = 1'b0;
        inj_ack++;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    int nz;
    nz = 0;
    for (int k = 0; k < 16; k++)
      for (int s = 0; s < 2; s++)
        if (step.alpha_fb[k][s] !== 16'h0) nz++;
    chk({tag, " en_step"},    step.en_step, 0);
    chk({tag, " busy"},       busy, 0);
    chk({tag, " done"},       done, 0);
    chk({tag, " converged"},  converged, 0);
    chk({tag, " iter_count"}, iter_count, 0);
    chk({tag, " max_delta"},  max_delta, 0);
    chk({tag, " policy"},     policy, 0);
    chk({tag, " alpha_fb nonzero words"}, nz, 0);
  endtask

  task automatic run_solve(input vec_t v, input bit chk_lat, input bit spur_start);
    exp_t e;
    int   base;
    bit   got;
    int   dcyc;
    int   nm;
    e = '{v.exp_conv, v.exp_iter, v.exp_delta, v.act, v.exp_steps, v.exp_d1};
    sb.push_back(e);
    cur_mode   = v.mode;
    cur_act    = v.act;
    alpha_init = init_set(v.mode);
    epsilon    = v.eps;
    max_iter   = v.mi;
    @(posedge clk);
    #1 start = 1'b1;
    base = step_total;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("launch en_step", step.en_step, 1);
    chk("launch busy", busy, 1);
    chk("launch done", done, 0);
    if (spur_start) begin
      @(posedge clk);
      #1;
      start      = 1'b1;
      alpha_init = ~alpha_init;
      epsilon    = 16'hFFFF;
      max_iter   = 8'd1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    got = 0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    dcyc = cyc;
    chk("done within budget", got, 1);
    if (sb.size() == 0) begin
      chk("scoreboard entries", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("converged", converged, e.conv);
      chk("iter_count", iter_count, e.iter);
      chk("max_delta", max_delta, e.delta);
      chk("policy", policy, e.pol);
      chk("en_step pulses", step_total - base, e.steps);
      if (e.steps >= 2) chk("max_delta after iteration 1", delta_log[base + 1], e.d1);
    end
    if (chk_lat) chk("en_loop to done cycles", dcyc - last_loop_cyc, 18);
    nm = 0;
    for (int k = 0; k < 16; k++)
      for (int s = 0; s < 2; s++)
        if (step.alpha_fb[k][s] !== last_resp[k][s]) nm++;
    chk("alpha_fb vs last result, mismatching words", nm, 0);
    chk("busy at done", busy, 0);
  endtask

  initial begin
    vec_t vt[9];
    int   base;
    bit   got;
    rst        = 1'b1;
    start      = 1'b0;
    alpha_init = '0;
    epsilon    = '0;
    max_iter   = '0;
    cur_mode   = M_IDENT;
    cur_act    = '0;
    spur_loop  = 1'b0;
    inj_req    = 0;

    vt[0] = '{M_IDENT,   16'd0,     8'd10, 32'h00000000, 1'b1, 8'd1, 16'd0,     1,   16'd0};
    vt[1] = '{M_SINGLE,  16'd299,   8'd10, 32'hE4E4E4E4, 1'b1, 8'd2, 16'd0,     2,   16'd300};
    vt[2] = '{M_SINGLE,  16'd300,   8'd10, 32'h1B1B1B1B, 1'b1, 8'd1, 16'd300,   1,   16'd0};
    vt[3] = '{M_ALT,     16'd10,    8'd3,  32'h5555AAAA, 1'b0, 8'd3, 16'h0400,  3,   16'h0400};
    vt[4] = '{M_EXT_HI,  16'hFFFF,  8'd5,  32'hAAAAAAAA, 1'b1, 8'd1, 16'hFFFF,  1,   16'd0};
    vt[5] = '{M_EXT_HI,  16'hFFFE,  8'd1,  32'hFFFFFFFF, 1'b0, 8'd1, 16'hFFFF,  1,   16'd0};
    vt[6] = '{M_EXT_MID, 16'h7FFF,  8'd2,  32'h0F0F0F0F, 1'b1, 8'd2, 16'd0,     2,   16'h8000};
    vt[7] = '{M_ALT,     16'h03FF,  8'd0,  32'h12345678, 1'b0, 8'd0, 16'h0400,  256, 16'h0400};
    vt[8] = '{M_ALT,     16'h0400,  8'd3,  32'h9ABCDEF0, 1'b1, 8'd1, 16'h0400,  1,   16'd0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");

    base = step_total;
    inj_req++;
    for (int i = 0; i < 20 && inj_ack != inj_req; i++) @(negedge clk);
    chk("idle en_loop injected", inj_ack, inj_req);
    repeat (3) @(negedge clk);
    check_idle_zero("idle en_loop");
    chk("idle en_loop en_step pulses", step_total - base, 0);

    for (int i = 0; i < 9; i++) run_solve(vt[i], 1'b1, 1'b0);

    spur_loop = 1'b1;
    run_solve(vt[1], 1'b0, 1'b1);
    spur_loop = 1'b0;

    // Reset while waiting for the first result; its late en_loop then lands in IDLE.
    cur_mode   = M_IDENT;
    cur_act    = 32'h1B1B1B1B;
    alpha_init = init_set(M_IDENT);
    epsilon    = 16'd0;
    max_iter   = 8'd4;
    @(posedge clk);
    #1 start = 1'b1;
    base = step_total;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset in WAIT");
    repeat (8) @(negedge clk);
    check_idle_zero("after reset in WAIT");
    chk("reset in WAIT en_step pulses", step_total - base, 1);
    run_solve(vt[0], 1'b1, 1'b0);

    // Reset during COMPARE at k=8, after points 0..7 have been written back.
    cur_mode   = M_ALT;
    cur_act    = 32'hAAAAAAAA;
    alpha_init = init_set(M_ALT);
    epsilon    = 16'd10;
    max_iter   = 8'd3;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (step.en_loop) begin
        got = 1;
        break;
      end
    end
    chk("en_loop before COMPARE reset", got, 1);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("k=8 policy[7]", policy[7], 2'd2);
    chk("k=8 policy[8]", policy[8], 2'd0);
    chk("k=8 alpha_fb[7][0]", step.alpha_fb[7][0], 16'h1400);
    chk("k=8 alpha_fb[8][0]", step.alpha_fb[8][0], 16'h1000);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset in COMPARE");
    repeat (3) @(negedge clk);
    run_solve(vt[0], 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pbvi_converge.md
# pbvi_converge

Downstream controller for the `step123` PBVI backup stage. It launches one backup, captures the returned alpha set and per-point action, and compares the new alpha set against the previous one point by point. It then either feeds the new set back as the next `alpha_in` and relaunches, or stops with a converged or iteration-limit status. Dimensions are fixed to match `step123`: 16 belief points, 2 states, unsigned Q0.16 values.

## Interface
Parameters:
- `NPT`, 16, number of belief points (alpha vectors).
- `NS`, 2, number of states per alpha vector.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle pulse that begins a solve; honoured only in IDLE or DONE.
- `alpha_init`  in  16 [0:15][0:1]  initial alpha set, sampled on the `start` cycle.
- `epsilon`  in  16  convergence threshold; sampled on `start`.
- `max_iter`  in  8  iteration limit; sampled on `start`; 0 means 256.
- `en_step`  out  1  one-cycle launch pulse to `step123.en`.
- `alpha_fb`  out  16 [0:15][0:1]  current alpha set, driving `step123.alpha_in`.
- `en_loop`  in  1  `step123` result-valid pulse.
- `alpha_out`  in  16 [0:15][0:1]  `step123` result alpha set.
- `point_action`  in  2 [0:15]  `step123` per-point best action.
- `policy`  out  2 [0:15]  per-point action from the latest iteration.
- `max_delta`  out  16  maximum abs difference from the latest completed iteration.
- `iter_count`  out  8  number of completed iterations.
- `busy`  out  1  high in LAUNCH, WAIT, COMPARE and DECIDE.
- `done`  out  1  high in DONE.
- `converged`  out  1  valid while `done`; 1 means the threshold was met.

## Operation
- States: IDLE, LAUNCH, WAIT, COMPARE, DECIDE, DONE.
- **IDLE/DONE + `start`:**
  - Load `alpha_fb` from `alpha_init`.
  - Latch `epsilon` and `max_iter`.
  - Clear `iter_count`, `max_delta`, `converged` and `policy`.
  - Go to LAUNCH.
- **LAUNCH:**
  - `en_step`=1 for this cycle only.
  - Clear the internal running maximum `run_max`.
  - Go to WAIT.
- **WAIT:**
  - Hold until `en_loop`=1.
  - On that cycle, capture `alpha_out` and `point_action` into capture registers `cap`/`cap_act`, set index k=0, and go to COMPARE.
- **COMPARE:** 16 cycles, k = 0..15. In each cycle:
  - d_s = |cap[k][s] − alpha_fb[k][s]| as a 16-bit unsigned absolute difference; a 17-bit intermediate is allowed, and no saturation is needed.
  - run_max = max(run_max, d_0, d_1).
  - alpha_fb[k] ← cap[k] and policy[k] ← cap_act[k] in the same cycle.
  - k=15 goes to DECIDE.
- **DECIDE:**
  - max_delta ← run_max; iter_count ← iter_count+1 (8-bit).
  - If run_max ≤ epsilon: converged←1, go to DONE.
  - Else if the new iter_count equals max_iter (8-bit compare, so 0 means 256): converged←0, go to DONE.
  - Otherwise go to LAUNCH.
- **DONE:** all outputs hold until `start` or `rst`.
- Ignored inputs:
  - `en_loop` outside WAIT has no effect.
  - `start` while `busy`=1 has no effect.
- `alpha_fb` changes only on the `start` cycle and during COMPARE. `step123` must not be relaunched until DECIDE completes, and the FSM guarantees this.

## Timing
- Reset values: state IDLE; `en_step`, `busy`, `done` and `converged` are 0; `alpha_fb`, `policy`, `max_delta` and `iter_count` are all 0.
- Reset mid-operation aborts in one cycle. The next cycle is IDLE with reset values, and no `en_step` is issued.
- Launch latency: `start` sampled at edge 0 → `en_step`=1 in cycle 1 → WAIT from cycle 2.
- Result path: `en_loop` sampled in cycle t → COMPARE in cycles t+1..t+16 → DECIDE in t+17 → LAUNCH (`en_step`=1) or DONE (`done`=1) in t+18.
- `alpha_fb[k]` takes its new value at the end of COMPARE cycle k.
- `en_step` is registered and asserted for exactly one cycle per iteration.
- A `start` in DONE takes the same path as from IDLE: `done` drops in cycle 1 and `busy` rises in cycle 1.

## Test plan
- **Identity model:** the bench returns `alpha_out` = `alpha_fb` 5 cycles after `en_step`; alpha_init = {13464,20673}…{20673,13464}; epsilon=0.
  - Expect one iteration, `done` with converged=1, iter_count=1, max_delta=0, and `done` high 18 cycles after `en_loop`.
- **Single change:**
  - Iteration 1 returns init with point 7, state 1 incremented by 300; epsilon=299.
  - Expect max_delta=300 and a relaunch.
  - Iteration 2 returns the same set; expect converged=1, iter_count=2, max_delta=0.
- **Iteration limit:**
  - The bench alternates between all-0x1000 and all-0x1400 sets; epsilon=10; max_iter=3.
  - Expect exactly 3 `en_step` pulses, then converged=0, iter_count=3, max_delta=0x0400.
- **Abs and extremes:**
  - Old 0xFFFF, new 0x0000 at point 0 → max_delta=0xFFFF.
  - Old 0x0000, new 0x8000 → max_delta=0x8000.
  - `policy` equals `point_action` after DECIDE, e.g. all points = 2'd2.
- **Spurious inputs:**
  - An `en_loop` pulse in IDLE and during COMPARE, and a `start` during WAIT, cause no state change.
  - No extra `en_step` occurs, and the iter_count sequence is unchanged.
- **Reset mid-WAIT and mid-COMPARE (k=8):**
  - The next cycle shows IDLE with all outputs 0.
  - A following `start` runs a clean identity solve with iter_count=1.
